// File: rtl/wptr_full_ctrl.sv
// Write-side full/level controller for a Gray-pointer async FIFO.
// The read pointer is synchronized into the write clock. Full, level and almost-full are registered from the next write pointer.
module wptr_full_ctrl #(
    parameter int PTR_WIDTH    = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = (1 << (PTR_WIDTH - 1)) - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PTR_WIDTH-1:0] wgray_nxt,
    input  logic                 wr_en,
    input  logic [PTR_WIDTH-1:0] rgray_async,
    input  logic                 clr_ovf,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH-1:0] wr_level,
    output logic [PTR_WIDTH-1:0] rgray_sync,
    output logic                 overflow
);

    localparam int MSB = PTR_WIDTH - 1;
    localparam logic [PTR_WIDTH-1:0] AFULL_T = PTR_WIDTH'(AFULL_THRESH);

    function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
        logic [PTR_WIDTH-1:0] b;
        b[MSB] = g[MSB];
        for (int i = MSB - 1; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic                 full_q, full_d;
    logic                 afull_q, afull_d;
    logic [PTR_WIDTH-1:0] level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [PTR_WIDTH-1:0] full_pat;

    assign rgray_sync = sync_q[SYNC_STAGES-1];

    // A write pointer one full lap ahead of the read pointer differs in the top two Gray bits only.
    assign full_pat = {~rgray_sync[MSB:MSB-1], rgray_sync[MSB-2:0]};

    always_comb begin
        full_d  = (wgray_nxt == full_pat);
        level_d = gray2bin(wgray_nxt) - gray2bin(rgray_sync);
        afull_d = (level_d >= AFULL_T);
        ovf_d   = ovf_q;
        if (wr_en && full_q) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q[0] <= rgray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            full_q  <= full_d;
            afull_q <= afull_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full        = full_q;
    assign almost_full = afull_q;
    assign wr_level    = level_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 8, Gray pointer width including wrap bit; FIFO depth DEPTH = 2^(PTR_WIDTH-1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, range 2..4, read-pointer synchronizer depth.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2, range 1..DEPTH, almost-full occupancy threshold.
REQ-004 Ports: clk  in  1  write-domain clock; one clock; all logic on rising edge.
REQ-005 Ports: rst  in  1  synchronous, active-high reset.
REQ-006 Ports: wgray_nxt  in  PTR_WIDTH  next-cycle Gray write pointer from the write-side Gray counter.
REQ-007 Ports: wr_en  in  1  write request, same cycle as the counter's inc.
REQ-008 Ports: rgray_async  in  PTR_WIDTH  Gray read pointer from the read clock domain, asynchronous.
REQ-009 Ports: clr_ovf  in  1  clears the sticky overflow flag.
REQ-010 Ports: full  out  1  registered full flag, fed back to the write counter.
REQ-011 Ports: almost_full  out  1  registered, occupancy >= AFULL_THRESH.
REQ-012 Ports: wr_level  out  PTR_WIDTH  registered occupancy, 0..DEPTH.
REQ-013 Ports: rgray_sync  out  PTR_WIDTH  final synchronizer stage.
REQ-014 Ports: overflow  out  1  sticky write-while-full error.

Function
REQ-015 rgray_async SHALL pass through a SYNC_STAGES-deep flop chain, no logic between stages; rgray_sync = last stage.
REQ-016 full SHALL register (wgray_nxt == {~rgray_sync[MSB:MSB-1], rgray_sync[MSB-2:0]}) every cycle.
REQ-017 Gray-to-binary SHALL be the standard XOR prefix: bin[MSB] = g[MSB], bin[i] = g[i] ^ bin[i+1].
REQ-018 level_nxt SHALL be (bin(wgray_nxt) - bin(rgray_sync)) modulo 2^PTR_WIDTH; wr_level SHALL register level_nxt.
REQ-019 almost_full SHALL register (level_nxt >= AFULL_THRESH); full SHALL imply almost_full in the same cycle.
REQ-020 full SHALL be 1 exactly when wr_level == DEPTH; the two SHALL never disagree.
REQ-021 Wrap-around: pointer wrap past 2^PTR_WIDTH-1 to 0 SHALL NOT disturb level, full or almost_full.
REQ-022 Write-side update: full/wr_level SHALL reflect a write on the same edge the write pointer registers it (zero added latency).
REQ-023 Read-side update: a change on rgray_async stable before edge N SHALL reach rgray_sync at edge N+SYNC_STAGES-1 and full/wr_level at edge N+SYNC_STAGES.
REQ-024 Pessimism: full and wr_level SHALL only overstate occupancy (stale read pointer), never understate.
REQ-025 Simultaneous write and read-pointer advance SHALL give level_nxt from both updated values; net zero change leaves wr_level unchanged.
REQ-026 overflow SHALL set on any edge where wr_en & full; clr_ovf SHALL clear it; set SHALL win over simultaneous clr_ovf.
REQ-027 Block SHALL contain no combinational path from rgray_async to any output.

Reset
REQ-028 While rst = 1 at an edge: all synchronizer stages, full, almost_full, wr_level, overflow SHALL load 0.
REQ-029 Reset asserted mid-operation SHALL take effect on the next edge regardless of wr_en, clr_ovf, or pointer state.
REQ-030 First edge after rst deassertion SHALL compute from live inputs; no extra settling cycles.

Verification (PTR_WIDTH=5, DEPTH=16, SYNC_STAGES=2, AFULL_THRESH=14)
REQ-031 Reset, all inputs 0 -> full=0, almost_full=0, wr_level=0, overflow=0, rgray_sync=0.
REQ-032 16 writes, rgray_async=0 -> wr_level counts 1..16; almost_full rises with 14th write; full rises with 16th write.
REQ-033 Full, rgray_async 0->1 (Gray) before edge N -> rgray_sync=1 at edge N+1; full=0, wr_level=15 at edge N+2.
REQ-034 wr_en=1 while full=1 -> overflow=1 next edge, held; clr_ovf pulse -> 0; wr_en&full with clr_ovf same cycle -> stays 1.
REQ-035 Run write/read pointers past 31->0 with level held at 8 -> wr_level=8 constant, full=0, almost_full=0.
REQ-036 rst pulsed for one cycle while full=1, overflow=1 -> all outputs 0 on that edge.
